// File: rtl/apb_master_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : apb_master_arbiter_if
// Brief    : Requester-side and APB-side signal bundle of apb_master_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface apb_master_arbiter_if #(
    parameter int MASTER_COUNT = 3,
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32
);
    logic [MASTER_COUNT-1:0]                 req_i;
    logic [MASTER_COUNT-1:0][ADDR_WIDTH-1:0] req_addr_i;
    logic [MASTER_COUNT-1:0]                 req_write_i;
    logic [MASTER_COUNT-1:0][DATA_WIDTH-1:0] req_wdata_i;
    logic [MASTER_COUNT-1:0]                 gnt_o;
    logic [MASTER_COUNT-1:0]                 done_o;
    logic [DATA_WIDTH-1:0]                   rdata_o;
    logic                                    slverr_o;
    logic                                    busy_o;

    logic                                    psel_o;
    logic                                    penable_o;
    logic                                    pwrite_o;
    logic [ADDR_WIDTH-1:0]                   paddr_o;
    logic [DATA_WIDTH-1:0]                   pwdata_o;
    logic                                    pready_i;
    logic                                    pslverr_i;
    logic [DATA_WIDTH-1:0]                   prdata_i;

    // Arbiter (APB master) view.
    modport master (
        input  req_i, req_addr_i, req_write_i, req_wdata_i,
        input  pready_i, pslverr_i, prdata_i,
        output gnt_o, done_o, rdata_o, slverr_o, busy_o,
        output psel_o, penable_o, pwrite_o, paddr_o, pwdata_o
    );

    // Environment view: requesters plus the muxed APB slave response.
    modport slave (
        output req_i, req_addr_i, req_write_i, req_wdata_i,
        output pready_i, pslverr_i, prdata_i,
        input  gnt_o, done_o, rdata_o, slverr_o, busy_o,
        input  psel_o, penable_o, pwrite_o, paddr_o, pwdata_o
    );
endinterface
`default_nettype wire

// File: rtl/apb_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : apb_master_arbiter
// Brief    : Round-robin arbiter sharing one APB master port, with timeout.
// Revision : 1.0 - initial release
// ============================================================================
module apb_master_arbiter #(
    parameter int MASTER_COUNT = 3,
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int TIMEOUT      = 16
) (
    input  wire logic            pclk_i,
    input  wire logic            presetn_i,
    apb_master_arbiter_if.master bus
);
    localparam int c_OWNER_W = (MASTER_COUNT > 1) ? $clog2(MASTER_COUNT) : 1;
    localparam int c_CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit c_TO_EN   = (TIMEOUT > 0);
    localparam logic [c_CNT_W-1:0]   c_CNT_LAST = c_CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [c_OWNER_W-1:0] c_LAST_RST = c_OWNER_W'(MASTER_COUNT - 1);
    localparam logic [c_OWNER_W:0]   c_MC_EXT   = (c_OWNER_W + 1)'(MASTER_COUNT);
    localparam logic [MASTER_COUNT-1:0] c_ONE   = MASTER_COUNT'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [c_OWNER_W-1:0]      r_owner;
    logic [c_OWNER_W-1:0]      r_last;
    logic [c_CNT_W-1:0]        r_cnt;
    logic [ADDR_WIDTH-1:0]     r_paddr;
    logic                      r_pwrite;
    logic [DATA_WIDTH-1:0]     r_pwdata;

    logic                      w_any_req;
    logic [2*MASTER_COUNT-1:0] w_req_rot;
    logic [c_OWNER_W-1:0]      w_offset;
    logic [c_OWNER_W:0]        w_sum;
    logic [c_OWNER_W-1:0]      w_winner;
    logic                      w_timeout;
    logic                      w_complete;

    // Rotate requests so bit 0 is the requester right after the last owner,
    // then take the lowest set bit and map it back to an absolute index.
    always_comb begin
        w_any_req = |bus.req_i;
        w_req_rot = {bus.req_i, bus.req_i} >> ({1'b0, r_last} + 1'b1);
        w_offset  = '0;
        for (int j = MASTER_COUNT - 1; j >= 0; j--) begin
            if (w_req_rot[j]) begin
                w_offset = c_OWNER_W'(j);
            end
        end
        w_sum = {1'b0, r_last} + 1'b1 + {1'b0, w_offset};
        if (w_sum >= c_MC_EXT) begin
            w_sum = w_sum - c_MC_EXT;
        end
        w_winner = w_sum[c_OWNER_W-1:0];
    end

    always_ff @(posedge pclk_i) begin
        if (!presetn_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_timeout     = 1'b0;
        w_complete    = 1'b0;
        bus.psel_o    = 1'b0;
        bus.penable_o = 1'b0;
        bus.busy_o    = 1'b0;
        bus.gnt_o     = '0;
        bus.done_o    = '0;
        bus.rdata_o   = '0;
        bus.slverr_o  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = S_SETUP;
                end
            end
            S_SETUP: begin
                bus.psel_o  = 1'b1;
                bus.busy_o  = 1'b1;
                bus.gnt_o   = c_ONE << r_owner;
                w_state_nxt = S_ACCESS;
            end
            S_ACCESS: begin
                bus.psel_o    = 1'b1;
                bus.penable_o = 1'b1;
                bus.busy_o    = 1'b1;
                bus.gnt_o     = c_ONE << r_owner;
                w_timeout     = c_TO_EN && !bus.pready_i && (r_cnt == c_CNT_LAST);
                w_complete    = bus.pready_i || w_timeout;
                if (w_complete) begin
                    w_state_nxt  = S_IDLE;
                    bus.done_o   = c_ONE << r_owner;
                    bus.slverr_o = bus.pready_i ? bus.pslverr_i : 1'b1;
                    if (bus.pready_i && !r_pwrite) begin
                        bus.rdata_o = bus.prdata_i;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk_i) begin
        if (!presetn_i) begin
            r_owner  <= '0;
            r_last   <= c_LAST_RST;
            r_cnt    <= '0;
            r_paddr  <= '0;
            r_pwrite <= 1'b0;
            r_pwdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_owner  <= w_winner;
                        r_paddr  <= bus.req_addr_i[w_winner];
                        r_pwrite <= bus.req_write_i[w_winner];
                        r_pwdata <= bus.req_wdata_i[w_winner];
                        r_cnt    <= '0;
                    end
                end
                S_ACCESS: begin
                    if (w_complete) begin
                        r_last <= r_owner;
                    end else if (c_TO_EN) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.paddr_o  = r_paddr;
    assign bus.pwrite_o = r_pwrite;
    assign bus.pwdata_o = r_pwdata;
endmodule
`default_nettype wire
